// File: rtl/voice_mixer.sv
// voice_mixer: folds NUM_VOICES gated, gain-scaled samples into one mono sample per frame.
// Optional MIXER_SATURATE_EN clamps out-of-range results and raises sticky clip.
module voice_mixer #(
    parameter int AUDIO_WIDTH = 32,
    parameter int NUM_VOICES  = 8,
    parameter int GAIN_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_valid,
    output logic                              in_ready,
    input  logic [NUM_VOICES*AUDIO_WIDTH-1:0] voices_in,
    input  logic [NUM_VOICES*GAIN_WIDTH-1:0]  gain_in,
    input  logic [NUM_VOICES-1:0]             note_on,
    output logic [AUDIO_WIDTH-1:0]            mix_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              clip,
    output logic                              drop
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int LOG_V  = $clog2(NUM_VOICES);
    localparam int PROD_W = AUDIO_WIDTH + GAIN_WIDTH + 1;
    localparam int ACC_W  = AUDIO_WIDTH + GAIN_WIDTH + LOG_V + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NUM_VOICES*AUDIO_WIDTH-1:0] voices_q;
    logic [NUM_VOICES*GAIN_WIDTH-1:0]  gains_q;
    logic [NUM_VOICES-1:0]             note_q;
    logic signed [ACC_W-1:0]           acc;
    logic [IDX_W-1:0]                  idx;

    logic [AUDIO_WIDTH-1:0]   voice_sel;
    logic [GAIN_WIDTH-1:0]    gain_sel;
    logic signed [PROD_W-1:0] v_ext;
    logic signed [PROD_W-1:0] g_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  shifted;
    logic [AUDIO_WIDTH-1:0]   result;

    assign in_ready  = (state_q == IDLE);

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign voice_sel = voices_q[idx*AUDIO_WIDTH +: AUDIO_WIDTH];
    assign gain_sel  = gains_q[idx*GAIN_WIDTH +: GAIN_WIDTH];
    assign v_ext     = PROD_W'($signed(voice_sel));
    assign g_ext     = PROD_W'({1'b0, gain_sel});
    assign prod      = v_ext * g_ext;
    assign term      = note_q[idx] ? ACC_W'(prod) : '0;

    // Remove the Q1.(GAIN_WIDTH-1) scale; arithmetic shift floors.
    assign shifted   = acc >>> (GAIN_WIDTH - 1);

`ifdef MIXER_SATURATE_EN
    logic [ACC_W-AUDIO_WIDTH:0] top;
    logic                       ovf;

    // In range only when all bits above the output sign agree with it.
    assign top = shifted[ACC_W-1:AUDIO_WIDTH-1];
    assign ovf = !((&top) || !(|top));

    // Clamp to the nearest representable extreme on overflow.
    always_comb begin
        result = shifted[AUDIO_WIDTH-1:0];
        if (ovf) begin
            result = shifted[ACC_W-1]
                   ? {1'b1, {(AUDIO_WIDTH-1){1'b0}}}
                   : {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
        end
    end

    // Sticky flag: any saturated result since reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clip <= 1'b0;
        end else if (state_q == SCALE && ovf) begin
            clip <= 1'b1;
        end
    end
`else
    logic unused_hi;

    assign result    = shifted[AUDIO_WIDTH-1:0];
    assign unused_hi = ^shifted[ACC_W-1:AUDIO_WIDTH];
    assign clip      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the frame sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_valid) state_d = ACCUM;
            ACCUM:   if (idx == LAST) state_d = SCALE;
            SCALE:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture, accumulate, scale and hand off one frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            voices_q  <= '0;
            gains_q   <= '0;
            note_q    <= '0;
            acc       <= '0;
            idx       <= '0;
            mix_out   <= '0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            if (sample_valid && state_q != IDLE) begin
                drop <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        voices_q <= voices_in;
                        gains_q  <= gain_in;
                        note_q   <= note_on;
                        acc      <= '0;
                        idx      <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + term;
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                SCALE: begin
                    mix_out   <= result;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
